// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor: parametrised UART receiver with an FWFT character FIFO and sticky error flags.
//
// Optional build macro: UART_RX_MON_GLITCH_FILTER_EN
//   defined   - a 3-sample majority filter follows the synchronizer; single-cycle
//               pulses on uart_rx are suppressed and line latency grows by 2 cycles.
//   undefined - the synchronized line feeds the receiver directly.
//
// Parameters:
//   CLK_DIV      mclk cycles per bit (2..65535)
//   DATA_BITS    character width (5..9)
//   PARITY_MODE  0 = none, 1 = even, 2 = odd
//   STOP_BITS    number of stop bits checked (1 or 2)
//   FIFO_AW      FIFO address width, depth = 2**FIFO_AW
//
// Ports:
//   mclk        system clock, rising edge
//   reset_n     asynchronous active-low reset
//   uart_rx     serial line, idle high, asynchronous to mclk
//   rd_en       pops the FIFO head when rd_valid is 1
//   err_clr     clears all sticky error flags
//   rd_data     FIFO head character (first-word-fall-through), 0 when empty
//   rd_valid    FIFO not empty
//   fifo_count  FIFO occupancy, 0..2**FIFO_AW
//   busy        receiver is inside a character (FSM not idle)
//   frame_err   sticky: a stop bit was sampled as 0
//   parity_err  sticky: parity mismatch
//   overrun     sticky: a good character was dropped because the FIFO was full
module uart_rx_monitor #(
    parameter int CLK_DIV     = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_AW     = 4
) (
    input  logic                 mclk,
    input  logic                 reset_n,
    input  logic                 uart_rx,
    input  logic                 rd_en,
    input  logic                 err_clr,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_valid,
    output logic [FIFO_AW:0]     fifo_count,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam logic [15:0] HALF_M1   = 16'(CLK_DIV / 2 - 1);
    localparam logic [15:0] DIV_M1    = 16'(CLK_DIV - 1);
    localparam logic [3:0]  DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state, state_n;
    logic                   rx_meta, rx_sync, rx_s, rx_s_prev;
    logic [15:0]            baud_cnt;
    logic [3:0]             bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_bit, stop_bad;
    logic                   tick, char_done;
    logic                   frame_bad, par_x, par_bad, good;
    logic                   push, pop, full, empty, ovr_set;
    logic [FIFO_AW:0]       wr_ptr, rd_ptr;
    logic [DATA_BITS-1:0]   mem [2**FIFO_AW];

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) {rx_meta, rx_sync} <= 2'b11;
        else          {rx_meta, rx_sync} <= {uart_rx, rx_meta};
    end

`ifdef UART_RX_MON_GLITCH_FILTER_EN
    // Majority of the last three synchronized samples: a lone flipped sample never wins.
    logic [2:0] filt;
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) filt <= 3'b111;
        else          filt <= {filt[1:0], rx_sync};
    end
    assign rx_s = (filt[0] & filt[1]) | (filt[0] & filt[2]) | (filt[1] & filt[2]);
`else
    assign rx_s = rx_sync;
`endif

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) rx_s_prev <= 1'b1;
        else          rx_s_prev <= rx_s;
    end

    assign tick = (baud_cnt == 16'd0);

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n   = state;
        char_done = 1'b0;
        case (state)
            IDLE:    if (rx_s_prev && !rx_s) state_n = START;
            START:   if (tick) state_n = rx_s ? IDLE : DATA;
            DATA:    if (tick && bit_cnt == DATA_LAST) state_n = (PARITY_MODE != 0) ? PARITY : STOP;
            PARITY:  if (tick) state_n = STOP;
            STOP: begin
                if (tick && bit_cnt == STOP_LAST) begin
                    state_n   = IDLE;
                    char_done = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // IDLE keeps the half-bit preload ready so the start sample lands mid-bit;
    // every later sample reloads a full bit period.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            baud_cnt <= 16'd0;
            bit_cnt  <= 4'd0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            stop_bad <= 1'b0;
        end else if (state == IDLE) begin
            baud_cnt <= HALF_M1;
            bit_cnt  <= 4'd0;
            stop_bad <= 1'b0;
        end else if (tick) begin
            baud_cnt <= DIV_M1;
            bit_cnt  <= (state_n != state) ? 4'd0 : bit_cnt + 4'd1;
            if (state == DATA)   shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            if (state == PARITY) par_bit <= rx_s;
            if (state == STOP && !rx_s) stop_bad <= 1'b1;
        end else begin
            baud_cnt <= baud_cnt - 16'd1;
        end
    end

    // The final stop sample is still on rx_s at the decision edge, so fold it in here.
    assign frame_bad = stop_bad | ~rx_s;
    assign par_x     = ^shreg ^ par_bit;
    assign par_bad   = (PARITY_MODE == 1) ? par_x : (PARITY_MODE == 2) ? ~par_x : 1'b0;
    assign good      = char_done & ~frame_bad & ~par_bad;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                      (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign rd_valid = ~empty;
    assign pop      = rd_en & rd_valid;
    // A pop on the same edge frees the slot a full FIFO would otherwise refuse.
    assign push     = good & (~full | rd_en);
    assign ovr_set  = good & full & ~rd_en;

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge mclk) begin
        if (push) mem[wr_ptr[FIFO_AW-1:0]] <= shreg;
    end

    assign rd_data    = rd_valid ? mem[rd_ptr[FIFO_AW-1:0]] : '0;
    assign fifo_count = wr_ptr - rd_ptr;
    assign busy       = (state != IDLE);

    // A new error on the clearing edge must survive, so the set term is ORed after the clear.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= (frame_err  & ~err_clr) | (char_done & frame_bad);
            parity_err <= (parity_err & ~err_clr) | (char_done & par_bad);
            overrun    <= (overrun    & ~err_clr) | ovr_set;
        end
    end

endmodule

// File: tb/tb_uart_rx_monitor.sv
// tb_uart_rx_monitor: scoreboard bench for three uart_rx_monitor configurations.
module tb_uart_rx_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rx [3];
    logic       rd_en [3];
    logic       err_clr [3];
    logic       rst_n [3];
    logic       rd_valid [3];
    logic       busy [3];
    logic       fe [3];
    logic       pe [3];
    logic       ov [3];
    logic [8:0] rdd [3];
    logic [4:0] cnt [3];

    logic [7:0] d0;
    logic [6:0] d1;
    logic [8:0] d2;
    logic [2:0] c0;
    logic [3:0] c1;
    logic [4:0] c2;

    assign rdd[0] = {1'b0, d0};
    assign rdd[1] = {2'b0, d1};
    assign rdd[2] = d2;
    assign cnt[0] = {2'b0, c0};
    assign cnt[1] = {1'b0, c1};
    assign cnt[2] = c2;

    uart_rx_monitor #(.CLK_DIV(16), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_AW(2)) dut0 (
        .mclk(clk), .reset_n(rst_n[0]), .uart_rx(rx[0]), .rd_en(rd_en[0]), .err_clr(err_clr[0]),
        .rd_data(d0), .rd_valid(rd_valid[0]), .fifo_count(c0), .busy(busy[0]),
        .frame_err(fe[0]), .parity_err(pe[0]), .overrun(ov[0]));

    uart_rx_monitor #(.CLK_DIV(7), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2), .FIFO_AW(3)) dut1 (
        .mclk(clk), .reset_n(rst_n[1]), .uart_rx(rx[1]), .rd_en(rd_en[1]), .err_clr(err_clr[1]),
        .rd_data(d1), .rd_valid(rd_valid[1]), .fifo_count(c1), .busy(busy[1]),
        .frame_err(fe[1]), .parity_err(pe[1]), .overrun(ov[1]));

    uart_rx_monitor #(.CLK_DIV(4), .DATA_BITS(9), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_AW(4)) dut2 (
        .mclk(clk), .reset_n(rst_n[2]), .uart_rx(rx[2]), .rd_en(rd_en[2]), .err_clr(err_clr[2]),
        .rd_data(d2), .rd_valid(rd_valid[2]), .fifo_count(c2), .busy(busy[2]),
        .frame_err(fe[2]), .parity_err(pe[2]), .overrun(ov[2]));

    function automatic int div(input int i);   return i == 0 ? 16 : i == 1 ? 7 : 4; endfunction
    function automatic int dbits(input int i); return i == 0 ? 8 : i == 1 ? 7 : 9;  endfunction
    function automatic int pmode(input int i); return i == 0 ? 0 : i == 1 ? 1 : 2;  endfunction
    function automatic int sbits(input int i); return i == 1 ? 2 : 1;               endfunction
    function automatic int depth(input int i); return i == 0 ? 4 : i == 1 ? 8 : 16; endfunction

    logic [8:0] q0 [$];
    logic [8:0] q1 [$];
    logic [8:0] q2 [$];
    bit m_fe [3];
    bit m_pe [3];
    bit m_ov [3];
    int n_vec = 0;
    int n_err = 0;

    function automatic int qsize(input int i);
        return i == 0 ? q0.size() : i == 1 ? q1.size() : q2.size();
    endfunction

    function automatic void qpush(input int i, input logic [8:0] d);
        if (i == 0) q0.push_back(d);
        else if (i == 1) q1.push_back(d);
        else q2.push_back(d);
    endfunction

    function automatic logic [8:0] qpop(input int i);
        if (i == 0) return q0.pop_front();
        if (i == 1) return q1.pop_front();
        return q2.pop_front();
    endfunction

    function automatic void model_reset(input int i);
        if (i == 0) q0.delete();
        else if (i == 1) q1.delete();
        else q2.delete();
        m_fe[i] = 0;
        m_pe[i] = 0;
        m_ov[i] = 0;
    endfunction

    task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d: got %0h expected %0h", name, i, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors: every pop the DUT performs is compared with the model's head.
    for (genvar g = 0; g < 3; g++) begin : g_mon
        initial forever begin
            @(negedge clk);
            if (rst_n[g] && rd_en[g] && rd_valid[g]) begin
                if (qsize(g) == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_pop inst%0d: got %0h expected none", g, rdd[g]);
                end else begin
                    logic [8:0] e;
                    e = qpop(g);
                    check("rd_data", g, 32'(rdd[g]), 32'(e));
                end
            end
        end
    end

    // Drives one frame from the character rules, then updates the reference model.
    task automatic send(input int i, input logic [8:0] d, input bit bad_par, input bit bad_stop, input int gap);
        int nb = dbits(i);
        int pm = pmode(i);
        int ns = sbits(i);
        int kb = $urandom_range(ns - 1, 0);
        logic [8:0] dm;
        bit bits [$];
        dm = d & 9'((1 << nb) - 1);
        bits.push_back(1'b0);
        for (int k = 0; k < nb; k++) bits.push_back(dm[k]);
        if (pm != 0) bits.push_back((($countones(dm) % 2) == 1) ^ (pm == 2) ^ bad_par);
        for (int k = 0; k < ns; k++) bits.push_back(!(bad_stop && k == kb));
        foreach (bits[k]) begin
            rx[i] = bits[k];
            repeat (div(i)) step();
        end
        rx[i] = 1'b1;
        repeat (gap) step();
        if (bad_stop) m_fe[i] = 1;
        if (pm != 0 && bad_par) m_pe[i] = 1;
        if (!bad_stop && !(pm != 0 && bad_par)) begin
            if (qsize(i) < depth(i)) qpush(i, dm);
            else m_ov[i] = 1;
        end
    endtask

    task automatic settle(input int i);
        repeat (div(i) + 8) step();
    endtask

    task automatic check_state(input int i);
        check("fifo_count", i, 32'(cnt[i]), 32'(qsize(i)));
        check("rd_valid", i, 32'(rd_valid[i]), 32'(qsize(i) != 0));
        check("frame_err", i, 32'(fe[i]), 32'(m_fe[i]));
        check("parity_err", i, 32'(pe[i]), 32'(m_pe[i]));
        check("overrun", i, 32'(ov[i]), 32'(m_ov[i]));
    endtask

    task automatic check_reset(input int i);
        check("rst_rd_data", i, 32'(rdd[i]), 0);
        check("rst_rd_valid", i, 32'(rd_valid[i]), 0);
        check("rst_count", i, 32'(cnt[i]), 0);
        check("rst_busy", i, 32'(busy[i]), 0);
        check("rst_flags", i, 32'({fe[i], pe[i], ov[i]}), 0);
    endtask

    task automatic drain(input int i);
        int k = 0;
        int n = qsize(i);
        rd_en[i] = 1'b1;
        while (rd_valid[i] && k < 40) begin
            step();
            k++;
        end
        rd_en[i] = 1'b0;
        check("pops", i, k, n);
        check("drained_valid", i, 32'(rd_valid[i]), 0);
        check("drained_model", i, qsize(i), 0);
    endtask

    task automatic clr(input int i);
        err_clr[i] = 1'b1;
        step();
        err_clr[i] = 1'b0;
        m_fe[i] = 0;
        m_pe[i] = 0;
        m_ov[i] = 0;
    endtask

    task automatic wait_busy(input int i, input bit level);
        for (int k = 0; k < 400 && busy[i] != level; k++) step();
        check("busy_wait", i, 32'(busy[i]), 32'(level));
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rx[i] = 1'b1;
            rd_en[i] = 1'b0;
            err_clr[i] = 1'b0;
            rst_n[i] = 1'b0;
        end
        repeat (4) step();
        for (int i = 0; i < 3; i++) check_reset(i);
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
        repeat (4) step();

        // 8N1 latency from start detection to visible push
        fork
            send(0, 9'h41, 0, 0, 4);
            begin
                int t = 0;
                wait_busy(0, 1);
                while (t < 400 && !rd_valid[0]) begin
                    step();
                    t++;
                end
                check("push_latency", 0, t, 152);
            end
        join
        settle(0);
        check_state(0);
        check("head", 0, 32'(rdd[0]), 32'h41);
        drain(0);

        // back-to-back characters, then popping an empty FIFO
        send(0, 9'h55, 0, 0, 0);
        send(0, 9'hAA, 0, 0, 0);
        send(0, 9'h00, 0, 0, 4);
        settle(0);
        check_state(0);
        drain(0);
        rd_en[0] = 1'b1;
        repeat (3) step();
        rd_en[0] = 1'b0;
        check_state(0);

        // even parity: bad then good, and error arriving on the clearing edge
        send(1, 9'h03, 1, 0, 8);
        settle(1);
        check_state(1);
        clr(1);
        check_state(1);
        send(1, 9'h03, 0, 0, 8);
        settle(1);
        check_state(1);
        drain(1);
        err_clr[1] = 1'b1;
        fork
            send(1, 9'h05, 1, 0, 8);
            begin
                wait_busy(1, 1);
                wait_busy(1, 0);
                err_clr[1] = 1'b0;
            end
        join
        settle(1);
        check_state(1);
        clr(1);

        // framing errors on both stop-bit configurations
        send(0, 9'h7E, 0, 1, 20);
        settle(0);
        check_state(0);
        send(0, 9'h11, 0, 0, 4);
        settle(0);
        check_state(0);
        drain(0);
        clr(0);
        send(1, 9'h2C, 0, 1, 14);
        settle(1);
        check_state(1);
        clr(1);

        // overrun on a depth-4 FIFO, then a pop on the push edge avoids it
        for (int b = 1; b <= 5; b++) send(0, 9'(8'hA0 + b), 0, 0, 2);
        settle(0);
        check_state(0);
        drain(0);
        clr(0);
        for (int b = 1; b <= 4; b++) send(0, 9'(8'hB0 + b), 0, 0, 2);
        fork
            send(0, 9'hB5, 0, 0, 4);
            begin
                wait_busy(0, 1);
                repeat (151) step();
                rd_en[0] = 1'b1;
                step();
                rd_en[0] = 1'b0;
            end
        join
        settle(0);
        check_state(0);
        drain(0);

        // randomized traffic on every configuration
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 24; n++) begin
                logic [8:0] d = 9'($urandom);
                bit bp = ($urandom_range(7, 0) == 0);
                bit bs = ($urandom_range(7, 0) == 0);
                int gap = bs ? div(i) * 2 : $urandom_range(div(i) * 2, 0);
                send(i, d, bp, bs, gap);
                if (qsize(i) == depth(i) || $urandom_range(3, 0) == 0) begin
                    settle(i);
                    check_state(i);
                    drain(i);
                end
                if ($urandom_range(5, 0) == 0) begin
                    settle(i);
                    check_state(i);
                    clr(i);
                end
            end
            settle(i);
            check_state(i);
            drain(i);
            clr(i);
        end

        // reset in the middle of a character
        send(0, 9'h33, 0, 0, 4);
        send(0, 9'h7E, 0, 1, 20);
        settle(0);
        check_state(0);
        fork
            send(0, 9'h5A, 0, 0, 4);
            begin
                repeat (16 * 4) step();
                rst_n[0] = 1'b0;
                #1;
                check_reset(0);
            end
        join
        model_reset(0);
        repeat (2) step();
        rst_n[0] = 1'b1;
        repeat (4) step();
        send(0, 9'h3C, 0, 0, 4);
        settle(0);
        check_state(0);
        check("head_after_reset", 0, 32'(rdd[0]), 32'h3C);
        drain(0);

        // single-cycle low glitch on an idle line
        begin
            bit seen = 0;
            rx[0] = 1'b0;
            step();
            rx[0] = 1'b1;
            for (int k = 0; k < 48; k++) begin
                step();
                if (busy[0]) seen = 1;
            end
`ifdef UART_RX_MON_GLITCH_FILTER_EN
            check("glitch_busy", 0, 32'(seen), 0);
`else
            check("glitch_false_start", 0, 32'(seen), 1);
`endif
            check("glitch_idle", 0, 32'(busy[0]), 0);
            check_state(0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_monitor.md
Name: uart_rx_monitor

Overview:
Synthesizable, parametrised UART receive monitor. It replaces the fixed 8N1 behavioural capture task used in top-level benches. It decodes a serial line clocked by mclk and supports configurable data width, parity and stop bits. Decoded characters are buffered in a first-word-fall-through (FWFT) FIFO with sticky error reporting, so benches and on-chip debug logic can drain them at their own pace.

Parameters:
CLK_DIV, 16, mclk cycles per bit (DCO_FREQ/BAUD); legal range 2..65535.
DATA_BITS, 8, character width; legal range 5..9.
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, number of stop bits checked; 1 or 2.
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW.

Ports:
mclk  input  1  system clock; all logic is rising-edge.
reset_n  input  1  asynchronous active-low reset.
uart_rx  input  1  serial line; idle high; asynchronous to mclk.
rd_en  input  1  pops the FIFO head when rd_valid is 1.
err_clr  input  1  clears all sticky error flags.
rd_data  output  DATA_BITS  FIFO head character (FWFT).
rd_valid  output  1  FIFO not empty.
fifo_count  output  FIFO_AW+1  occupancy, 0..2**FIFO_AW.
busy  output  1  FSM is not in IDLE.
frame_err  output  1  sticky; a stop bit was sampled as 0.
parity_err  output  1  sticky; parity mismatch.
overrun  output  1  sticky; a good character was dropped because the FIFO was full.

Behaviour:
- Reset values: rd_data 0, rd_valid 0, fifo_count 0, busy 0, all error flags 0, FSM in IDLE, FIFO pointers 0.
- Synchronizer: uart_rx passes through a 2-FF synchronizer (reset value 1), giving rx_s.
- Start detection: rx_s_prev=1 and rx_s=0 while in IDLE → go to START and load baud_cnt.
- FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE.
- START: wait CLK_DIV/2 cycles (floor), then sample rx_s.
  - Sample is 1 → false start; return to IDLE with no flag and no push.
  - Sample is 0 → go to DATA.
- Bit sampling: after START, every bit is sampled once at CLK_DIV-cycle spacing (mid-bit). baud_cnt reloads on each sample.
- DATA: shift LSB first; DATA_BITS samples.
- PARITY: present only when PARITY_MODE≠0. Even parity: XOR(data, parity bit) must be 0. Odd parity: it must be 1.
- STOP: STOP_BITS samples.
  - Any stop sample of 0 → frame_err.
  - Decision is taken on the final stop sample edge.
  - Character with a frame or parity error → not pushed; set the corresponding flag(s).
  - Good character with FIFO not full, or full with rd_en=1 in the same cycle → pushed.
  - Good character with FIFO full and no rd_en → dropped; set overrun.
- Return from STOP: FSM returns to IDLE on the cycle after the final stop sample. A start edge is accepted immediately, so back-to-back characters need no extra idle time.
- Push latency: rd_valid rises 1 cycle after the push edge. For 8N1 with CLK_DIV=16, the push occurs 152 cycles (CLK_DIV/2 + 9·CLK_DIV) after start-edge detection.
- Pop: rd_en with rd_valid=1 advances the read pointer; the next head appears the following cycle. rd_en while empty is ignored.
- Simultaneous push and pop: fifo_count is unchanged; data ordering is preserved.
- Pointer wrap: pointers are FIFO_AW+1 bits; full/empty is resolved by the MSB.
- Error flags: hold until err_clr. If err_clr and a new error occur in the same cycle, the new error wins (flag stays 1).
- busy is 1 in every state except IDLE.
- Reset mid-character: everything returns to reset values immediately; no partial push.

Optional Feature:
UART_RX_MON_GLITCH_FILTER_EN
- Defined: a 3-sample majority filter follows the synchronizer. Single-cycle pulses on uart_rx are suppressed. Line latency grows by 2 cycles, so push timing shifts +2. Filter reset state is 111.
- Undefined: rx_s feeds the FSM directly; a 1-cycle low pulse triggers START and resolves as a false start.

Test Plan:
- 8N1, CLK_DIV=16: send 0x41 → 152 cycles after edge detect, push occurs; rd_valid=1, rd_data=0x41, fifo_count=1, no error flags set.
- Back-to-back bytes 0x55, 0xAA, 0x00 with no idle gap → FIFO holds 0x55, 0xAA, 0x00 in order; rd_en pops them one per cycle; rd_valid falls after the third pop.
- PARITY_MODE=1: send 0x03 with parity bit 1 → parity_err=1, nothing pushed. Pulse err_clr → parity_err=0. Send 0x03 with parity bit 0 → pushed.
- Stop bit forced low on 0x7E → frame_err=1, fifo_count unchanged. Next valid byte 0x11 is received normally.
- FIFO_AW=2: send 5 bytes without reading → fifo_count=4, overrun=1, contents are bytes 1–4. Repeat with rd_en asserted on the 5th push edge → no overrun, fifo_count stays 4.
- Assert reset_n low mid-DATA → all outputs 0 and busy 0 at once. Send a byte after release → received correctly. With the filter enabled, a 1-cycle low glitch on uart_rx → busy stays 0.
